// File: rtl/mem_port_arbiter.sv
// Arbitrates one Avalon master between i-cache refill (m0) and data port (m1); whole transactions.
// Latency: command on s_* one cycle after grant; read beats forwarded combinationally to the owner.
// Backpressure: s_waitrequest stalls CMD with s_* held; m*_waitrequest low only on acceptance. ARB_FIXED_PRIORITY_EN selects fixed m0 priority.
module mem_port_arbiter #(
    parameter int DATA_W  = 128,
    parameter int BURST_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        m0_address,
    input  logic               m0_read,
    input  logic [BURST_W-1:0] m0_burstcount,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,
    input  logic [31:0]        m1_address,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [DATA_W-1:0]  m1_writedata,
    input  logic [BURST_W-1:0] m1_burstcount,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,
    output logic [31:0]        s_address,
    output logic               s_read,
    output logic               s_write,
    output logic [DATA_W-1:0]  s_writedata,
    output logic [BURST_W-1:0] s_burstcount,
    input  logic               s_waitrequest,
    input  logic [DATA_W-1:0]  s_readdata,
    input  logic               s_readdatavalid
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               owner;          // 0: m0 owns the transaction, 1: m1
    logic [BURST_W-1:0] beat_cnt;
    logic               req0;
    logic               req1;
    logic               grant1;
    logic               grant_wr;
    logic [BURST_W-1:0] burst_sel;
    logic [BURST_W-1:0] burst_norm;
    logic               cmd_accept;
    logic               last_beat;

    assign req0 = m0_read;
    assign req1 = m1_read | m1_write;

`ifdef ARB_FIXED_PRIORITY_EN
    assign grant1 = req1 & ~req0;
`else
    logic last_grant;

    // On contention the port that did not win last time takes the grant.
    assign grant1 = req1 & (~req0 | ~last_grant);
`endif

    // A simultaneous m1 read stays pending behind the write.
    assign grant_wr   = grant1 & m1_write;
    assign burst_sel  = grant1 ? m1_burstcount : m0_burstcount;
    assign burst_norm = (grant_wr || burst_sel == '0) ? BURST_W'(1) : burst_sel;

    assign cmd_accept = (state == CMD) & ~s_waitrequest;
    assign last_beat  = s_readdatavalid & (beat_cnt == BURST_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (!s_waitrequest) begin
                    state_nxt = s_write ? IDLE : DATA;
                end
            end
            DATA: begin
                if (last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_address    <= '0;
            s_writedata  <= '0;
            s_burstcount <= '0;
            s_read       <= 1'b0;
            s_write      <= 1'b0;
            owner        <= 1'b0;
            beat_cnt     <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            last_grant   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        s_address    <= grant1 ? m1_address : m0_address;
                        s_burstcount <= burst_norm;
                        s_read       <= ~grant_wr;
                        s_write      <= grant_wr;
                        owner        <= grant1;
`ifndef ARB_FIXED_PRIORITY_EN
                        last_grant   <= grant1;
`endif
                        if (grant_wr) begin
                            s_writedata <= m1_writedata;
                        end
                    end
                end
                CMD: begin
                    if (!s_waitrequest) begin
                        s_read   <= 1'b0;
                        s_write  <= 1'b0;
                        beat_cnt <= s_burstcount;
                    end
                end
                DATA: begin
                    if (s_readdatavalid) begin
                        beat_cnt <= beat_cnt - BURST_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Beats outside DATA are stray and go nowhere.
    assign m0_waitrequest   = ~(cmd_accept & ~owner);
    assign m1_waitrequest   = ~(cmd_accept & owner);
    assign m0_readdatavalid = (state == DATA) & s_readdatavalid & ~owner;
    assign m1_readdatavalid = (state == DATA) & s_readdatavalid & owner;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

endmodule
